reg_rename_file: RTL and testbench

//   Architectural register file with per-register rename tags. Sits downstream of the ROB commit port.

---
 rtl/reg_rename_file.sv | 138 +++++++++++++
 tb/tb_reg_rename_file.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Register file with per-register rename tags for an out-of-order core.
//
// Each architectural register holds a committed value, a busy flag and the
// ROB tag of its newest in-flight producer. The issue stage looks up two
// source operands and gets back either a ready value or the tag to wait on.
// The ROB commit port writes values back and releases registers. A branch
// mispredict flush drops every pending rename.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), synchronous active-low reset
//   i_rdy                   global enable; low freezes all state
//   i_is_*                  issue: valid, rs1, rs2, dest, allocated ROB tag
//   o_is_rdy/val/tag{1,2}   resolved operands for rs1/rs2
//   o_rob_ord{1,2}          tag presented to the ROB for forwarding
//   i_rob_rdy/val{1,2}      ROB forwarding response for that tag
//   i_commit_*              commit: valid, dest, value, ROB tag
//   i_jp_wrong              mispredict flush
module reg_rename_file #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREG  = 32,
    parameter int unsigned ROB_W = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_rdy,

    input  logic                    i_is_sgn,
    input  logic [$clog2(NREG)-1:0] i_is_rs1,
    input  logic [$clog2(NREG)-1:0] i_is_rs2,
    input  logic [$clog2(NREG)-1:0] i_is_dest,
    input  logic [ROB_W-1:0]        i_is_rob_name,
    output logic                    o_is_rdy1,
    output logic                    o_is_rdy2,
    output logic [XLEN-1:0]         o_is_val1,
    output logic [XLEN-1:0]         o_is_val2,
    output logic [ROB_W-1:0]        o_is_tag1,
    output logic [ROB_W-1:0]        o_is_tag2,

    output logic [ROB_W-1:0]        o_rob_ord1,
    output logic [ROB_W-1:0]        o_rob_ord2,
    input  logic                    i_rob_rdy1,
    input  logic                    i_rob_rdy2,
    input  logic [XLEN-1:0]         i_rob_val1,
    input  logic [XLEN-1:0]         i_rob_val2,

    input  logic                    i_commit_sgn,
    input  logic [$clog2(NREG)-1:0] i_commit_dest,
    input  logic [XLEN-1:0]         i_commit_value,
    input  logic [ROB_W-1:0]        i_commit_rob_name,

    input  logic                    i_jp_wrong
);

    localparam int unsigned RegW = $clog2(NREG);

    logic [XLEN-1:0]  r_value [NREG];
    logic [ROB_W-1:0] r_tag   [NREG];
    logic [NREG-1:0]  r_busy;

    // Both read ports share one resolution loop.
    logic [RegW-1:0]  w_rs      [2];
    logic             w_rob_rdy [2];
    logic [XLEN-1:0]  w_rob_val [2];
    logic             w_rdy     [2];
    logic [XLEN-1:0]  w_val     [2];
    logic [ROB_W-1:0] w_tag     [2];

    assign w_rs[0]      = i_is_rs1;
    assign w_rs[1]      = i_is_rs2;
    assign w_rob_rdy[0] = i_rob_rdy1;
    assign w_rob_rdy[1] = i_rob_rdy2;
    assign w_rob_val[0] = i_rob_val1;
    assign w_rob_val[1] = i_rob_val2;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_rdy[k] = 1'b1;
            w_val[k] = '0;
            w_tag[k] = r_tag[w_rs[k]];
            if (w_rs[k] == '0) begin
                w_val[k] = '0;
            end else if (!r_busy[w_rs[k]]) begin
                w_val[k] = r_value[w_rs[k]];
            end else if (i_commit_sgn && (i_commit_dest == w_rs[k]) &&
                         (i_commit_rob_name == r_tag[w_rs[k]])) begin
                // Producer is committing right now: bypass its value.
                w_val[k] = i_commit_value;
            end else if (w_rob_rdy[k]) begin
                // Producer finished but not yet committed: forward from ROB.
                w_val[k] = w_rob_val[k];
            end else begin
                w_rdy[k] = 1'b0;
            end
        end
    end

    assign o_is_rdy1  = w_rdy[0];
    assign o_is_rdy2  = w_rdy[1];
    assign o_is_val1  = w_val[0];
    assign o_is_val2  = w_val[1];
    assign o_is_tag1  = w_tag[0];
    assign o_is_tag2  = w_tag[1];
    assign o_rob_ord1 = r_tag[i_is_rs1];
    assign o_rob_ord2 = r_tag[i_is_rs2];

    logic w_rename;
    logic w_commit;
    assign w_rename = i_is_sgn && (i_is_dest != '0) && !i_jp_wrong;
    assign w_commit = i_commit_sgn && (i_commit_dest != '0);

    // Later non-blocking writes override earlier ones: commit release, then
    // a same-cycle rename re-busies the register, then a flush clears all.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy <= '0;
        end else if (i_rdy) begin
            if (w_commit) begin
                r_value[i_commit_dest] <= i_commit_value;
                // A stale commit (older producer) must not release the register.
                if (r_tag[i_commit_dest] == i_commit_rob_name) begin
                    r_busy[i_commit_dest] <= 1'b0;
                end
            end
            if (w_rename) begin
                r_busy[i_is_dest] <= 1'b1;
                r_tag[i_is_dest]  <= i_is_rob_name;
            end
            if (i_jp_wrong) begin
                r_busy <= '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        is_sgn;
    logic [4:0]  is_rs1, is_rs2, is_dest;
    logic [3:0]  is_rob_name;
    logic        is_rdy1, is_rdy2;
    logic [31:0] is_val1, is_val2;
    logic [3:0]  is_tag1, is_tag2;
    logic [3:0]  rob_ord1, rob_ord2;
    logic        rob_rdy1, rob_rdy2;
    logic [31:0] rob_val1, rob_val2;
    logic        commit_sgn;
    logic [4:0]  commit_dest;
    logic [31:0] commit_value;
    logic [3:0]  commit_rob_name;
    logic        jp_wrong;

    always #5 clk = ~clk;

    reg_rename_file #(.XLEN(32), .NREG(32), .ROB_W(4)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_rdy             (rdy),
        .i_is_sgn          (is_sgn),
        .i_is_rs1          (is_rs1),
        .i_is_rs2          (is_rs2),
        .i_is_dest         (is_dest),
        .i_is_rob_name     (is_rob_name),
        .o_is_rdy1         (is_rdy1),
        .o_is_rdy2         (is_rdy2),
        .o_is_val1         (is_val1),
        .o_is_val2         (is_val2),
        .o_is_tag1         (is_tag1),
        .o_is_tag2         (is_tag2),
        .o_rob_ord1        (rob_ord1),
        .o_rob_ord2        (rob_ord2),
        .i_rob_rdy1        (rob_rdy1),
        .i_rob_rdy2        (rob_rdy2),
        .i_rob_val1        (rob_val1),
        .i_rob_val2        (rob_val2),
        .i_commit_sgn      (commit_sgn),
        .i_commit_dest     (commit_dest),
        .i_commit_value    (commit_value),
        .i_commit_rob_name (commit_rob_name),
        .i_jp_wrong        (jp_wrong)
    );

    typedef struct {
        logic        rst_n, rdy, is_sgn;
        logic [4:0]  rs1, rs2, dest;
        logic [3:0]  name;
        logic        rob_rdy1, rob_rdy2;
        logic [31:0] rob_val1, rob_val2;
        logic        csgn;
        logic [4:0]  cdest;
        logic [31:0] cval;
        logic [3:0]  cname;
        logic        jp;
    } stim_t;

    typedef struct {
        string       name;
        bit          chk_tag;
        logic        rdy1, rdy2;
        logic [31:0] val1, val2;
        logic [3:0]  tag1, tag2;
    } exp_t;

    // Reference state: what each architectural register holds.
    logic [31:0] m_value [32];
    logic [3:0]  m_tag   [32];
    bit          m_busy  [32];

    exp_t  sb[$];
    stim_t cur;
    int    n_vec = 0;
    int    n_err = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1'b1, rdy: 1'b1, is_sgn: 1'b0, rs1: 5'd0, rs2: 5'd0, dest: 5'd0,
              name: 4'd0, rob_rdy1: 1'b0, rob_rdy2: 1'b0, rob_val1: 32'd0, rob_val2: 32'd0,
              csgn: 1'b0, cdest: 5'd0, cval: 32'd0, cname: 4'd0, jp: 1'b0};
        return s;
    endfunction

    // State change at a clock edge, applied in the order the rules state.
    task automatic model_edge(input stim_t s);
        bit renamed;
        if (!s.rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_value[i] = 0; m_tag[i] = 0; m_busy[i] = 0;
            end
        end else if (s.rdy) begin
            renamed = s.is_sgn && s.dest != 0 && !s.jp;
            if (s.csgn && s.cdest != 0) begin
                m_value[s.cdest] = s.cval;
                if (m_tag[s.cdest] == s.cname && !(renamed && s.dest == s.cdest))
                    m_busy[s.cdest] = 0;
            end
            if (renamed) begin
                m_busy[s.dest] = 1;
                m_tag[s.dest]  = s.name;
            end
            if (s.jp)
                for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end
    endtask

    task automatic model_lookup(input logic [4:0] r, input logic rrdy, input logic [31:0] rval,
                                input stim_t s, output logic rd, output logic [31:0] v,
                                output logic [3:0] t);
        t  = m_tag[r];
        rd = 1'b1;
        v  = 32'd0;
        if (r == 0)                                               v = 32'd0;
        else if (!m_busy[r])                                      v = m_value[r];
        else if (s.csgn && s.cdest == r && s.cname == m_tag[r])   v = s.cval;
        else if (rrdy)                                            v = rval;
        else                                                      rd = 1'b0;
    endtask

    // One cycle: the model takes the edge with the inputs that were applied,
    // then new inputs go out and the expected response is queued.
    task automatic step(input stim_t s, input string nm, input bit chk_tag);
        exp_t e;
        @(posedge clk);
        model_edge(cur);
        #1;
        cur = s;
        rst_n = s.rst_n; rdy = s.rdy; is_sgn = s.is_sgn;
        is_rs1 = s.rs1; is_rs2 = s.rs2; is_dest = s.dest; is_rob_name = s.name;
        rob_rdy1 = s.rob_rdy1; rob_rdy2 = s.rob_rdy2; rob_val1 = s.rob_val1; rob_val2 = s.rob_val2;
        commit_sgn = s.csgn; commit_dest = s.cdest; commit_value = s.cval;
        commit_rob_name = s.cname; jp_wrong = s.jp;
        e.name = nm;
        e.chk_tag = chk_tag;
        model_lookup(s.rs1, s.rob_rdy1, s.rob_val1, s, e.rdy1, e.val1, e.tag1);
        model_lookup(s.rs2, s.rob_rdy2, s.rob_val2, s, e.rdy2, e.val2, e.tag2);
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.name, ".rdy1"}, 32'(is_rdy1), 32'(e.rdy1));
            chk({e.name, ".rdy2"}, 32'(is_rdy2), 32'(e.rdy2));
            chk({e.name, ".val1"}, is_val1, e.val1);
            chk({e.name, ".val2"}, is_val2, e.val2);
            chk({e.name, ".ord1"}, 32'(rob_ord1), 32'(e.tag1));
            chk({e.name, ".ord2"}, 32'(rob_ord2), 32'(e.tag2));
            if (!e.rdy1 || e.chk_tag) chk({e.name, ".tag1"}, 32'(is_tag1), 32'(e.tag1));
            if (!e.rdy2 || e.chk_tag) chk({e.name, ".tag2"}, 32'(is_tag2), 32'(e.tag2));
        end
    end

    initial begin
        stim_t s;
        cur = idle();
        cur.rst_n = 1'b0;
        rst_n = 1'b0; rdy = 1'b1; is_sgn = 1'b0; is_rs1 = 0; is_rs2 = 0; is_dest = 0;
        is_rob_name = 0; rob_rdy1 = 0; rob_rdy2 = 0; rob_val1 = 0; rob_val2 = 0;
        commit_sgn = 0; commit_dest = 0; commit_value = 0; commit_rob_name = 0; jp_wrong = 0;

        s = idle(); s.rst_n = 1'b0;
        step(s, "in_reset", 1'b1);
        s = idle(); s.rs1 = 5; s.rs2 = 0;
        step(s, "after_reset", 1'b1);

        s = idle(); s.is_sgn = 1; s.dest = 3; s.name = 7;
        step(s, "issue_x3_t7", 1'b0);
        s = idle(); s.rs1 = 3;
        step(s, "x3_pending", 1'b0);
        s = idle(); s.rs1 = 3; s.rob_rdy1 = 1; s.rob_val1 = 32'hABCD;
        step(s, "x3_rob_fwd", 1'b0);
        s = idle(); s.rs1 = 3; s.csgn = 1; s.cdest = 3; s.cname = 7; s.cval = 32'h55;
        step(s, "x3_commit_bypass", 1'b0);
        s = idle(); s.rs1 = 3;
        step(s, "x3_released", 1'b0);

        s = idle(); s.is_sgn = 1; s.dest = 3; s.name = 7;
        step(s, "rename_x3_t7", 1'b0);
        s = idle(); s.is_sgn = 1; s.dest = 3; s.name = 9;
        step(s, "rename_x3_t9", 1'b0);
        s = idle(); s.rs1 = 3; s.csgn = 1; s.cdest = 3; s.cname = 7; s.cval = 32'h11;
        step(s, "stale_commit", 1'b0);
        s = idle(); s.rs1 = 3;
        step(s, "x3_still_t9", 1'b0);
        s = idle(); s.rs1 = 3; s.csgn = 1; s.cdest = 3; s.cname = 9; s.cval = 32'h99;
        step(s, "commit_t9", 1'b0);
        s = idle(); s.rs2 = 3;
        step(s, "x3_final", 1'b0);

        s = idle(); s.is_sgn = 1; s.dest = 4; s.name = 2;
        s.csgn = 1; s.cdest = 4; s.cname = 0; s.cval = 32'h44;
        step(s, "issue_commit_x4", 1'b0);
        s = idle(); s.rs1 = 4;
        step(s, "x4_busy_t2", 1'b0);

        s = idle(); s.csgn = 1; s.cdest = 1; s.cval = 32'h111;
        step(s, "init_x1", 1'b0);
        s = idle(); s.csgn = 1; s.cdest = 2; s.cval = 32'h222;
        s.is_sgn = 1; s.dest = 1; s.name = 5;
        step(s, "init_x2_busy_x1", 1'b0);
        s = idle(); s.is_sgn = 1; s.dest = 2; s.name = 6;
        step(s, "busy_x2", 1'b0);
        s = idle(); s.rs1 = 1; s.rs2 = 2; s.jp = 1; s.is_sgn = 1; s.dest = 5; s.name = 1;
        step(s, "flush", 1'b0);
        s = idle(); s.rs1 = 1; s.rs2 = 2;
        step(s, "after_flush", 1'b0);
        s = idle(); s.rs1 = 5;
        step(s, "flush_drops_issue", 1'b0);

        s = idle(); s.is_sgn = 1; s.dest = 0; s.name = 3;
        step(s, "issue_x0", 1'b0);
        s = idle(); s.rs1 = 0; s.rs2 = 0;
        step(s, "x0_ready", 1'b1);

        s = idle(); s.rdy = 0; s.is_sgn = 1; s.dest = 6; s.name = 8;
        s.csgn = 1; s.cdest = 1; s.cval = 32'hDEAD;
        step(s, "frozen", 1'b0);
        s = idle(); s.rs1 = 6; s.rs2 = 1;
        step(s, "after_frozen", 1'b0);

        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.rst_n    = ($urandom_range(0, 199) != 0);
            s.rdy      = ($urandom_range(0, 9) != 0);
            s.is_sgn   = $urandom_range(0, 1);
            s.rs1      = 5'($urandom_range(0, 7));
            s.rs2      = 5'($urandom_range(0, 7));
            s.dest     = 5'($urandom_range(0, 7));
            s.name     = 4'($urandom);
            s.rob_rdy1 = $urandom_range(0, 1);
            s.rob_rdy2 = $urandom_range(0, 1);
            s.rob_val1 = $urandom;
            s.rob_val2 = $urandom;
            s.csgn     = $urandom_range(0, 1);
            s.cdest    = 5'($urandom_range(0, 7));
            s.cval     = $urandom;
            s.cname    = ($urandom_range(0, 1) != 0) ? m_tag[s.cdest] : 4'($urandom);
            s.jp       = ($urandom_range(0, 19) == 0);
            step(s, "random", 1'b0);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
